// File: rtl/nios_mem_copy_pkg.sv
// Shared types and sizing constants for the on-chip memory block-copy master.
// The state enum is shared so other blocks in this slice can decode copier state.
package nios_mem_copy_pkg;

  localparam int DEFAULT_ADDR_W = 14;
  localparam int DEFAULT_DATA_W = 32;
  localparam int MEM_DEPTH      = 12288;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAT,
    WRITE,
    DONE
  } copy_state_t;

endpackage

// File: rtl/mem_copy_ptr_ctr.sv
// Word pointer with load/increment (wrapping at 2^PTR_W) paired with a counter
// that flags when its next increment reaches cnt_limit.
module mem_copy_ptr_ctr #(
  parameter int PTR_W = 14,
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ptr_load,
  input  logic [PTR_W-1:0] ptr_init,
  input  logic             ptr_inc,
  input  logic             cnt_clr,
  input  logic             cnt_inc,
  input  logic [CNT_W-1:0] cnt_limit,
  output logic [PTR_W-1:0] ptr,
  output logic             cnt_last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (ptr_load)
        ptr <= ptr_init;
      else if (ptr_inc)
        ptr <= ptr + PTR_W'(1);

      if (cnt_clr)
        cnt <= '0;
      else if (cnt_inc)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Terminal count looks one step ahead so the FSM can branch on the same edge.
  assign cnt_last = ((cnt + CNT_W'(1)) == cnt_limit);

endmodule

// File: rtl/nios_system_mem_copy_master.sv
// Avalon-MM master on the on-chip memory s2 port that copies a block of words
// from a source range to a destination range, one word in flight at a time.
module nios_system_mem_copy_master
  import nios_mem_copy_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                write,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  output logic                clken,
  input  logic [DATA_W-1:0]   readdata
);

  // READ_LATENCY is only meaningful in 1..3, so two bits hold the LAT limit.
  localparam logic [1:0] LAT_LIMIT = 2'(READ_LATENCY);

  copy_state_t       state;
  logic [ADDR_W:0]   length_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              word_last;
  logic              lat_last;
  logic              accept;

  assign accept     = (state == IDLE) && start;
  assign byteenable = '1;
  assign clken      = 1'b1;

  // Source pointer plus the copied-word counter.
  mem_copy_ptr_ctr #(
    .PTR_W (ADDR_W),
    .CNT_W (ADDR_W + 1)
  ) u_src (
    .clk       (clk),
    .reset     (reset),
    .ptr_load  (accept),
    .ptr_init  (src_addr),
    .ptr_inc   (state == WRITE),
    .cnt_clr   (accept),
    .cnt_inc   (state == WRITE),
    .cnt_limit (length_q),
    .ptr       (src_ptr),
    .cnt_last  (word_last)
  );

  // Destination pointer; its counter paces the read-latency wait.
  mem_copy_ptr_ctr #(
    .PTR_W (ADDR_W),
    .CNT_W (2)
  ) u_dst (
    .clk       (clk),
    .reset     (reset),
    .ptr_load  (accept),
    .ptr_init  (dst_addr),
    .ptr_inc   (state == WRITE),
    .cnt_clr   (state == READ),
    .cnt_inc   (state == LAT),
    .cnt_limit (LAT_LIMIT),
    .ptr       (dst_ptr),
    .cnt_last  (lat_last)
  );

  // Bus outputs are set on the edge entering each state, so they never depend
  // combinationally on readdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      length_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            length_q <= length;
            busy     <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= READ;
              chipselect <= 1'b1;
              write      <= 1'b0;
              address    <= src_addr;
            end
          end
        end
        READ: begin
          state      <= LAT;
          chipselect <= 1'b0;
        end
        LAT: begin
          if (lat_last) begin
            writedata  <= readdata;
            state      <= WRITE;
            chipselect <= 1'b1;
            write      <= 1'b1;
            address    <= dst_ptr;
          end
        end
        WRITE: begin
          write <= 1'b0;
          if (word_last) begin
            state      <= DONE;
            chipselect <= 1'b0;
            done       <= 1'b1;
          end else begin
            state      <= READ;
            chipselect <= 1'b1;
            address    <= src_ptr + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          chipselect <= 1'b0;
          write      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_mem_copy_master.sv
// Bench for the block-copy master: two instances (read latency 1 and 2), each
// attached to a behavioural memory, checked against a word-by-word copy model.
module tb_nios_system_mem_copy_master;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   length;

  logic          busy_a, done_a, cs_a, write_a, clken_a;
  logic [AW-1:0] address_a;
  logic [3:0]    be_a;
  logic [DW-1:0] wdata_a, rdata_a;

  logic          busy_b, done_b, cs_b, write_b, clken_b;
  logic [AW-1:0] address_b;
  logic [3:0]    be_b;
  logic [DW-1:0] wdata_b, rdata_b;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] ref_a [DEPTH];
  logic [DW-1:0] ref_b [DEPTH];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [2];
  logic          pre_we_a, pre_we_b;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nios_system_mem_copy_master #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .busy(busy_a), .done(done_a),
    .address(address_a), .chipselect(cs_a), .write(write_a),
    .byteenable(be_a), .writedata(wdata_a), .clken(clken_a), .readdata(rdata_a)
  );

  nios_system_mem_copy_master #(.READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .busy(busy_b), .done(done_b),
    .address(address_b), .chipselect(cs_b), .write(write_b),
    .byteenable(be_b), .writedata(wdata_b), .clken(clken_b), .readdata(rdata_b)
  );

  // Memories with 1- and 2-cycle read latency plus a bench preload port.
  always @(posedge clk) begin
    if (pre_we_a) mem_a[pre_addr] <= pre_data;
    else if (cs_a && write_a) mem_a[address_a] <= wdata_a;
    pipe_a <= mem_a[address_a];
    if (pre_we_b) mem_b[pre_addr] <= pre_data;
    else if (cs_b && write_b) mem_b[address_b] <= wdata_b;
    pipe_b[0] <= mem_b[address_b];
    pipe_b[1] <= pipe_b[0];
  end
  assign rdata_a = pipe_a;
  assign rdata_b = pipe_b[1];

  // Cumulative bus/handshake monitors; tests work on deltas.
  int busy_cnt_a = 0, done_cnt_a = 0, cs_cnt_a = 0, orphan_a = 0;
  int busy_cnt_b = 0, done_cnt_b = 0, cs_cnt_b = 0, orphan_b = 0;
  logic [AW-1:0] rd_log_a[$], wr_log_a[$], rd_log_b[$], wr_log_b[$];

  always @(negedge clk) begin
    if (busy_a) busy_cnt_a += 1;
    if (done_a) done_cnt_a += 1;
    if (done_a && !busy_a) orphan_a += 1;
    if (cs_a) begin
      cs_cnt_a += 1;
      if (write_a) wr_log_a.push_back(address_a);
      else rd_log_a.push_back(address_a);
    end
    if (busy_b) busy_cnt_b += 1;
    if (done_b) done_cnt_b += 1;
    if (done_b && !busy_b) orphan_b += 1;
    if (cs_b) begin
      cs_cnt_b += 1;
      if (write_b) wr_log_b.push_back(address_b);
      else rd_log_b.push_back(address_b);
    end
  end

  task automatic preload(input bit use_b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    if (use_b) pre_we_b = 1'b1;
    else pre_we_a = 1'b1;
    @(negedge clk);
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
    if (use_b) ref_b[a] = d;
    else ref_a[a] = d;
  endtask

  task automatic preload_random(input bit use_b, input logic [AW-1:0] a, input int n);
    for (int i = 0; i < n; i++) preload(use_b, a + AW'(i), $urandom);
  endtask

  // One complete copy, checked for timing, handshake, bus addresses and data.
  task automatic run_copy(input string tag, input bit use_b, input logic [AW-1:0] s,
                          input logic [AW-1:0] d, input int n, input bit junk);
    int b0, d0, c0, o0, r0, w0, lat, bad, exp_busy, rsz, wsz;
    bit seen;
    logic [AW-1:0] a;
    logic [DW-1:0] got, exp;
    lat = use_b ? 2 : 1;
    exp_busy = n * (2 + lat) + 1;
    for (int i = 0; i < n; i++) begin
      if (use_b) ref_b[d + AW'(i)] = ref_b[s + AW'(i)];
      else ref_a[d + AW'(i)] = ref_a[s + AW'(i)];
    end
    @(negedge clk);
    b0 = use_b ? busy_cnt_b : busy_cnt_a;
    d0 = use_b ? done_cnt_b : done_cnt_a;
    c0 = use_b ? cs_cnt_b : cs_cnt_a;
    o0 = use_b ? orphan_b : orphan_a;
    r0 = use_b ? rd_log_b.size() : rd_log_a.size();
    w0 = use_b ? wr_log_b.size() : wr_log_a.size();
    src_addr = s;
    dst_addr = d;
    length   = (AW+1)'(n);
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < exp_busy + 8; c++) begin
      if ((use_b ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (junk) begin
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        length   = (AW+1)'($urandom_range(1, 20));
        start_a  = (c % 4 == 1);
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    #1;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s done_timeout: done not seen, required within %0d cycles", tag, exp_busy + 8);
    end
    vectors++;
    if ((use_b ? busy_cnt_b : busy_cnt_a) - b0 !== exp_busy) begin
      miscompares++;
      $display("[TB] FAIL %s busy_cycles: got %0d required %0d", tag,
               (use_b ? busy_cnt_b : busy_cnt_a) - b0, exp_busy);
    end
    vectors++;
    if ((use_b ? done_cnt_b : done_cnt_a) - d0 !== 1) begin
      miscompares++;
      $display("[TB] FAIL %s done_pulses: got %0d required 1", tag,
               (use_b ? done_cnt_b : done_cnt_a) - d0);
    end
    vectors++;
    if ((use_b ? orphan_b : orphan_a) - o0 !== 0) begin
      miscompares++;
      $display("[TB] FAIL %s done_outside_busy: got %0d required 0", tag,
               (use_b ? orphan_b : orphan_a) - o0);
    end
    vectors++;
    if ((use_b ? cs_cnt_b : cs_cnt_a) - c0 !== 2 * n) begin
      miscompares++;
      $display("[TB] FAIL %s chipselect_cycles: got %0d required %0d", tag,
               (use_b ? cs_cnt_b : cs_cnt_a) - c0, 2 * n);
    end
    bad = 0;
    rsz = (use_b ? rd_log_b.size() : rd_log_a.size()) - r0;
    wsz = (use_b ? wr_log_b.size() : wr_log_a.size()) - w0;
    if (rsz != n || wsz != n) bad++;
    else begin
      for (int i = 0; i < n; i++) begin
        if ((use_b ? rd_log_b[r0 + i] : rd_log_a[r0 + i]) !== s + AW'(i)) bad++;
        if ((use_b ? wr_log_b[w0 + i] : wr_log_a[w0 + i]) !== d + AW'(i)) bad++;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL %s bus_addresses: got %0d reads/%0d writes with %0d wrong, required %0d each from src 0x%h dst 0x%h",
               tag, rsz, wsz, bad, n, s, d);
    end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      a   = d + AW'(i);
      got = use_b ? mem_b[a] : mem_a[a];
      exp = use_b ? ref_b[a] : ref_a[a];
      if (got !== exp) begin
        if (bad == 0)
          $display("[TB] FAIL %s dst_data[0x%h]: got 0x%h required 0x%h", tag, a, got, exp);
        bad++;
      end
    end
    vectors++;
    if (bad != 0) miscompares++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy_a, done_a, cs_a, write_a, address_a, wdata_a, be_a, clken_a} !==
        {4'b0000, 14'h0, 32'h0, 4'hF, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_a: got %0b/%0b/%0b/%0b addr 0x%h wd 0x%h be 0x%h ck %0b required 0/0/0/0 0 0 F 1",
               busy_a, done_a, cs_a, write_a, address_a, wdata_a, be_a, clken_a);
    end
    vectors++;
    if ({busy_b, done_b, cs_b, write_b, address_b, wdata_b, be_b, clken_b} !==
        {4'b0000, 14'h0, 32'h0, 4'hF, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_b: got busy %0b cs %0b addr 0x%h wd 0x%h required 0 0 0 0",
               busy_b, cs_b, address_b, wdata_b);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    for (int i = 0; i < 4; i++) preload(0, 14'h0010 + AW'(i), 32'hA000_0000 + DW'(i));
    preload_random(0, 14'h0100, 4);
    run_copy("basic4", 0, 14'h0010, 14'h0100, 4, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem_a[14'h0100 + AW'(i)] !== 32'hA000_0000 + DW'(i)) begin
        miscompares++;
        $display("[TB] FAIL basic4_word%0d: got 0x%h required 0x%h", i,
                 mem_a[14'h0100 + AW'(i)], 32'hA000_0000 + DW'(i));
      end
    end
  endtask

  task automatic test_zero_length();
    run_copy("zero_len", 0, AW'($urandom), AW'($urandom), 0, 0);
  endtask

  task automatic test_wrap();
    preload_random(0, 14'h3FFE, 4);
    run_copy("wrap", 0, 14'h3FFE, 14'h3FFF, 3, 0);
  endtask

  task automatic test_start_ignored();
    logic [AW-1:0] s, d;
    s = AW'($urandom_range(0, 16'h1FFF));
    d = s + 14'h2000;
    preload_random(0, s, 6);
    preload_random(0, d, 6);
    run_copy("start_ignored", 0, s, d, 6, 1);
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] s, d;
    s = 14'h0200;
    d = 14'h0400;
    preload_random(0, s, 8);
    preload_random(0, d, 8);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = 15'd8;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy_a, cs_a, write_a} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL mid_lat_state: got busy/cs/wr %b required 100", {busy_a, cs_a, write_a});
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({busy_a, done_a, cs_a, write_a, address_a, wdata_a} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got busy %0b cs %0b wr %0b addr 0x%h wd 0x%h required all 0",
               busy_a, cs_a, write_a, address_a, wdata_a);
    end
    @(negedge clk);
    reset = 1'b0;
    ref_a[d] = ref_a[s];
    vectors++;
    if (mem_a[d] !== ref_a[d] || mem_a[d + 14'd1] !== ref_a[d + 14'd1]) begin
      miscompares++;
      $display("[TB] FAIL partial_copy: got 0x%h 0x%h required 0x%h 0x%h",
               mem_a[d], mem_a[d + 14'd1], ref_a[d], ref_a[d + 14'd1]);
    end
    preload_random(0, 14'h0600, 5);
    run_copy("after_reset", 0, 14'h0600, 14'h0700, 5, 0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] s[3], d[3];
    int n[3];
    for (int k = 0; k < 3; k++) begin
      s[k] = AW'($urandom);
      d[k] = (k == 2) ? s[k] + 14'd2 : AW'($urandom);
      n[k] = $urandom_range(1, 10);
      preload_random(0, s[k], n[k]);
      preload_random(0, d[k], n[k]);
    end
    for (int k = 0; k < 3; k++) run_copy($sformatf("b2b%0d", k), 0, s[k], d[k], n[k], 0);
  endtask

  task automatic test_latency2();
    logic [AW-1:0] s;
    s = AW'($urandom);
    preload_random(1, s, 5);
    preload_random(1, s + 14'h1000, 5);
    run_copy("latency2", 1, s, s + 14'h1000, 5, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    test_reset();
    test_basic_copy();
    test_zero_length();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_latency2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
